// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings (transfer type, size, response) and the byte-lane
// strobe decode used by the register-file bridges.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_e;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // Lane mask for a naturally aligned transfer; sizes above a word select nothing.
   function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] addr_lo);
      logic [3:0] mask;
      case (size)
         HSIZE_BYTE: mask = 4'b0001 << addr_lo;
         HSIZE_HALF: mask = 4'b0011 << addr_lo;
         HSIZE_WORD: mask = 4'b1111;
         default:    mask = 4'b0000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/ahb_reg_bridge_if.sv
// AHB-Lite subordinate signal bundle between the interconnect (manager side)
// and ahb_reg_bridge (subordinate side).
interface ahb_reg_bridge_if #(
   parameter int AddrWidth = 12
);
   logic                 hsel;
   logic [AddrWidth-1:0] haddr;
   logic [1:0]           htrans;
   logic                 hwrite;
   logic [2:0]           hsize;
   logic [31:0]          hwdata;
   logic                 hready;
   logic                 hreadyout;
   logic                 hresp;
   logic [31:0]          hrdata;

   modport mgr (
      output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
      input  hreadyout, hresp, hrdata
   );

   modport sub (
      input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
      output hreadyout, hresp, hrdata
   );
endinterface

// File: rtl/ahb_reg_bridge.sv
// AHB-Lite subordinate front end for a word-addressed register file: zero-wait OKAY
// data phase for legal transfers, two-cycle ERROR (one stall) for illegal ones.
module ahb_reg_bridge
   import ahb_pkg::*;
#(
   parameter int  NumWords    = 64,
   parameter int  AddrWidth   = 12,
   localparam int OffsetWidth = $clog2(NumWords)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   ahb_reg_bridge_if.sub          ahb,
   output logic [OffsetWidth-1:0] offset,
   output logic [31:0]            wd,
   output logic [3:0]             we,
   input  logic [31:0]            rd
);

   localparam int IdxWidth = AddrWidth - 2;
   // One extra bit so NumWords == 2**IdxWidth still compares correctly.
   localparam logic [IdxWidth:0] NumWordsExt = NumWords[IdxWidth:0];

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WR,
      ST_ERR1,
      ST_ERR2
   } state_e;

   state_e                 state_q, state_d;
   logic [OffsetWidth-1:0] offset_q, offset_d;
   logic [1:0]             alo_q, alo_d;
   logic [2:0]             size_q, size_d;

   logic [IdxWidth-1:0] word_idx;
   logic                accept;
   logic                size_ok;
   logic                aligned;
   logic                in_range;
   logic                legal;

   always_comb begin
      word_idx = ahb.haddr[AddrWidth-1:2];
      accept   = ahb.hsel && ahb.hready
                 && (htrans_e'(ahb.htrans) inside {HTRANS_NONSEQ, HTRANS_SEQ});
      size_ok  = (ahb.hsize <= HSIZE_WORD);
      if (ahb.hsize == HSIZE_HALF) begin
         aligned = !ahb.haddr[0];
      end else if (ahb.hsize == HSIZE_WORD) begin
         aligned = (ahb.haddr[1:0] == 2'b00);
      end else begin
         aligned = 1'b1;
      end
      in_range = ({1'b0, word_idx} < NumWordsExt);
      legal    = size_ok && aligned && in_range;
   end

   always_comb begin
      state_d       = state_q;
      offset_d      = offset_q;
      alo_d         = alo_q;
      size_d        = size_q;
      ahb.hreadyout = 1'b1;
      ahb.hresp     = HRESP_OKAY;
      ahb.hrdata    = '0;
      we            = '0;

      // ERR1 holds hready low, so no address phase can complete there.
      if (state_q == ST_ERR1) begin
         state_d = ST_ERR2;
      end else if (ahb.hready) begin
         if (accept) begin
            offset_d = word_idx[OffsetWidth-1:0];
            alo_d    = ahb.haddr[1:0];
            size_d   = ahb.hsize;
            if (!legal) begin
               state_d = ST_ERR1;
            end else if (ahb.hwrite) begin
               state_d = ST_WR;
            end else begin
               state_d = ST_RD;
            end
         end else begin
            state_d = ST_IDLE;
         end
      end

      unique case (state_q)
         ST_RD:   ahb.hrdata = rd;
         ST_WR:   we = byte_strobe(size_q, alo_q);
         ST_ERR1: begin
            ahb.hreadyout = 1'b0;
            ahb.hresp     = HRESP_ERROR;
         end
         ST_ERR2: ahb.hresp = HRESP_ERROR;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         offset_q <= '0;
         alo_q    <= '0;
         size_q   <= '0;
      end else begin
         state_q  <= state_d;
         offset_q <= offset_d;
         alo_q    <= alo_d;
         size_q   <= size_d;
      end
   end

   assign offset = offset_q;
   assign wd     = ahb.hwdata;

endmodule

// File: tb/tb_ahb_reg_bridge.sv
// Bench for ahb_reg_bridge: directed AHB-Lite sequences with literal expectations, then
// randomized traffic, all compared each cycle against a transaction-level model.
module tb_ahb_reg_bridge;
   import ahb_pkg::*;

   localparam int NumWords    = 64;
   localparam int AddrWidth   = 12;
   localparam int OffsetWidth = $clog2(NumWords);

   logic                   clk     = 1'b0;
   logic                   reset_n = 1'b0;
   logic [OffsetWidth-1:0] offset;
   logic [31:0]            wd;
   logic [31:0]            rd;
   logic [3:0]             we;
   int                     n_cmp = 0;
   int                     n_bad = 0;

   ahb_reg_bridge_if #(.AddrWidth(AddrWidth)) bus ();

   ahb_reg_bridge #(.NumWords(NumWords), .AddrWidth(AddrWidth)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .ahb    (bus),
      .offset (offset),
      .wd     (wd),
      .we     (we),
      .rd     (rd)
   );

   always #5 clk = ~clk;

   // Single subordinate on the bus: the bus-level ready is our own ready.
   assign bus.hready = bus.hreadyout;

   // Register file behind the bridge.
   logic [31:0] rf [NumWords] = '{default: 32'h0};
   always @(posedge clk)
      for (int b = 0; b < 4; b++)
         if (we[b]) rf[offset][8*b +: 8] <= wd[8*b +: 8];
   assign rd = rf[offset];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum {K_NONE, K_RD, K_WR, K_ERR} kind_e;
   kind_e       cur_kind   = K_NONE;
   int          err_left   = 0;
   int          cur_idx    = 0;
   logic [3:0]  cur_lanes  = 4'h0;
   int          exp_offset = 0;
   logic [31:0] model_mem [NumWords] = '{default: 32'h0};
   logic        exp_ready, exp_resp;
   logic [31:0] exp_rdata;
   logic [3:0]  exp_we;
   int          m_addr, m_idx, m_nbytes, m_alo;

   initial begin : compare
      forever begin
         @(negedge clk);
         #2;
         if (!reset_n) begin
            check("rst_hreadyout", 32'(bus.hreadyout), 32'd1);
            check("rst_hresp",     32'(bus.hresp),     32'd0);
            check("rst_hrdata",    bus.hrdata,         32'd0);
            check("rst_we",        32'(we),            32'd0);
            check("rst_offset",    32'(offset),        32'd0);
            cur_kind   = K_NONE;
            exp_offset = 0;
         end else begin
            exp_ready = !(cur_kind == K_ERR && err_left == 2);
            exp_resp  = (cur_kind == K_ERR);
            exp_rdata = (cur_kind == K_RD) ? model_mem[cur_idx] : 32'h0;
            exp_we    = (cur_kind == K_WR) ? cur_lanes : 4'h0;
            check("hreadyout", 32'(bus.hreadyout), 32'(exp_ready));
            check("hresp",     32'(bus.hresp),     32'(exp_resp));
            check("hrdata",    bus.hrdata,         exp_rdata);
            check("we",        32'(we),            32'(exp_we));
            check("offset",    32'(offset),        32'(exp_offset));
            check("wd",        wd,                 bus.hwdata);

            if (cur_kind == K_WR)
               for (int b = 0; b < 4; b++)
                  if (cur_lanes[b]) model_mem[cur_idx][8*b +: 8] = bus.hwdata[8*b +: 8];

            if (cur_kind == K_ERR && err_left == 2) begin
               err_left = 1;
            end else if (bus.hsel && bus.htrans >= 2'd2) begin
               m_addr     = int'(bus.haddr);
               m_idx      = m_addr / 4;
               m_alo      = m_addr % 4;
               exp_offset = m_idx % NumWords;
               m_nbytes   = 1 << bus.hsize;
               if (bus.hsize > 3'd2 || (m_addr % m_nbytes) != 0 || m_idx >= NumWords) begin
                  cur_kind = K_ERR;
                  err_left = 2;
               end else begin
                  cur_kind  = bus.hwrite ? K_WR : K_RD;
                  cur_idx   = m_idx;
                  cur_lanes = 4'h0;
                  for (int b = 0; b < 4; b++)
                     if (b >= m_alo && b < m_alo + m_nbytes) cur_lanes[b] = 1'b1;
               end
            end else begin
               cur_kind = K_NONE;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   typedef struct packed {
      logic                 sel;
      logic [1:0]           trans;
      logic                 write;
      logic [2:0]           size;
      logic [AddrWidth-1:0] addr;
      logic [31:0]          wdata;
   } xfer_t;

   logic [31:0] dp_wdata = 32'h0;

   function automatic xfer_t mk(input logic wr, input logic [2:0] sz, input logic [AddrWidth-1:0] a,
                                input logic [31:0] d, input logic [1:0] tr = 2'd2);
      xfer_t x;
      x.sel = 1'b1; x.trans = tr; x.write = wr; x.size = sz; x.addr = a; x.wdata = d;
      return x;
   endfunction

   task automatic present(input xfer_t x);
      bus.hsel   = x.sel;
      bus.htrans = x.trans;
      bus.hwrite = x.write;
      bus.hsize  = x.size;
      bus.haddr  = x.addr;
   endtask

   // One address phase; drives the previous transfer's write data and holds through stalls.
   task automatic issue(input xfer_t x);
      int guard = 0;
      @(negedge clk);
      bus.hwdata = dp_wdata;
      present(x);
      dp_wdata = x.wdata;
      while (bus.hreadyout !== 1'b1) begin
         guard++;
         if (guard > 4) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stall_bound: hreadyout low for %0d cycles, expected at most 1", guard);
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic idle_cycle();
      xfer_t x;
      x       = '0;
      x.sel   = 1'($urandom);
      x.trans = 2'($urandom_range(0, 1));
      x.addr  = AddrWidth'($urandom);
      x.wdata = $urandom;
      @(negedge clk);
      bus.hwdata = dp_wdata;
      present(x);
      dp_wdata = x.wdata;
   endtask

   xfer_t rx;

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin : main
      present('0);
      bus.hwdata = 32'h0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // Word write then back-to-back read of the same word.
      issue(mk(1'b1, HSIZE_WORD, 12'h010, 32'hDEADBEEF));
      issue(mk(1'b0, HSIZE_WORD, 12'h010, 32'h0));
      #3;
      check("t1_we_word", 32'(we), 32'hF);
      check("t1_ready_wr", 32'(bus.hreadyout), 32'd1);
      idle_cycle();
      #3;
      check("t1_raw_rdata", bus.hrdata, 32'hDEADBEEF);
      check("t1_ready_rd", 32'(bus.hreadyout), 32'd1);

      // Byte and halfword lanes merged into a cleared word.
      issue(mk(1'b1, HSIZE_WORD, 12'h010, 32'h0));
      issue(mk(1'b1, HSIZE_BYTE, 12'h013, 32'hA5776655));
      issue(mk(1'b1, HSIZE_HALF, 12'h010, 32'h99991234));
      #3;
      check("t2_we_byte3", 32'(we), 32'h8);
      issue(mk(1'b0, HSIZE_WORD, 12'h010, 32'h0));
      #3;
      check("t2_we_half0", 32'(we), 32'h3);
      idle_cycle();
      #3;
      check("t2_rdata", bus.hrdata, 32'hA5001234);
      check("t2_model_word", model_mem[4], 32'hA5001234);

      // Misaligned halfword write: two-cycle error, no write.
      issue(mk(1'b1, HSIZE_HALF, 12'h011, 32'hFFFFFFFF));
      idle_cycle();
      #3;
      check("t3_err1_ready", 32'(bus.hreadyout), 32'd0);
      check("t3_err1_resp",  32'(bus.hresp),     32'd1);
      check("t3_err1_we",    32'(we),            32'd0);
      idle_cycle();
      #3;
      check("t3_err2_ready", 32'(bus.hreadyout), 32'd1);
      check("t3_err2_resp",  32'(bus.hresp),     32'd1);
      check("t3_err2_we",    32'(we),            32'd0);
      issue(mk(1'b0, HSIZE_WORD, 12'h010, 32'h0));
      idle_cycle();
      #3;
      check("t3_unchanged", bus.hrdata, 32'hA5001234);

      // Out-of-range read.
      issue(mk(1'b0, HSIZE_WORD, 12'h100, 32'h0));
      idle_cycle();
      #3;
      check("t4_err1_ready", 32'(bus.hreadyout), 32'd0);
      check("t4_err1_resp",  32'(bus.hresp),     32'd1);
      check("t4_err1_rdata", bus.hrdata,         32'd0);
      idle_cycle();
      #3;
      check("t4_err2_ready", 32'(bus.hreadyout), 32'd1);
      check("t4_err2_resp",  32'(bus.hresp),     32'd1);
      check("t4_err2_rdata", bus.hrdata,         32'd0);

      // Oversized write errors; BUSY write is ignored.
      issue(mk(1'b1, 3'd3, 12'h020, 32'h11111111));
      idle_cycle();
      #3;
      check("t5_size3_resp",  32'(bus.hresp),     32'd1);
      check("t5_size3_ready", 32'(bus.hreadyout), 32'd0);
      idle_cycle();
      issue(mk(1'b1, HSIZE_WORD, 12'h020, 32'h22222222, 2'd1));
      idle_cycle();
      #3;
      check("t5_busy_resp", 32'(bus.hresp),     32'd0);
      check("t5_busy_we",   32'(we),            32'd0);
      check("t5_busy_ready", 32'(bus.hreadyout), 32'd1);
      issue(mk(1'b0, HSIZE_WORD, 12'h020, 32'h0));
      idle_cycle();
      #3;
      check("t5_word_zero", bus.hrdata, 32'h0);

      // Reset in the middle of a write data phase drops the write.
      issue(mk(1'b1, HSIZE_WORD, 12'h020, 32'h55AA55AA));
      @(negedge clk);
      bus.hwdata = dp_wdata;
      present('0);
      dp_wdata = 32'h0;
      #1;
      reset_n = 1'b0;
      #2;
      check("t6_rst_we",    32'(we),            32'd0);
      check("t6_rst_ready", 32'(bus.hreadyout), 32'd1);
      check("t6_rst_resp",  32'(bus.hresp),     32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      issue(mk(1'b0, HSIZE_WORD, 12'h020, 32'h0));
      idle_cycle();
      #3;
      check("t6_dropped", bus.hrdata, 32'h0);
      check("t6_model_word", model_mem[8], 32'h0);

      // Randomized traffic, concentrated on a few words for read-after-write reuse.
      for (int i = 0; i < 400; i++) begin
         rx.sel   = ($urandom_range(0, 9) != 0);
         rx.trans = 2'($urandom_range(0, 3));
         rx.write = 1'($urandom);
         rx.size  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         case ($urandom_range(0, 7))
            0:       rx.addr = AddrWidth'($urandom);
            1:       rx.addr = AddrWidth'($urandom_range(12'h0F0, 12'h10F));
            default: rx.addr = AddrWidth'($urandom_range(0, 12'h03F));
         endcase
         if ($urandom_range(0, 3) != 0 && rx.size <= 3'd2)
            rx.addr = rx.addr & ~AddrWidth'((1 << rx.size) - 1);
         rx.wdata = $urandom;
         issue(rx);
      end
      repeat (4) idle_cycle();
      @(negedge clk);
      #3;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ahb_reg_bridge.md
Name: ahb_reg_bridge

Overview:
- AHB-Lite subordinate front end for the word-addressed register file.
- Converts AHB address/data phases into the file's offset / write-data / byte-enable / read-data port.
- Zero-wait-state OKAY for legal transfers; two-cycle ERROR for illegal ones.
- Sits between the interconnect decoder (HSEL) and the register file instance.

Parameters:
- NumWords, 64, number of 32-bit registers behind the bridge; OffsetWidth = $clog2(NumWords) (localparam)
- AddrWidth, 12, HADDR bits decoded by this subordinate; must satisfy NumWords*4 <= 2**AddrWidth

Ports:
- clk  input  1  clock
- reset_n  input  1  reset, asynchronous, active-low
- hsel  input  1  subordinate select
- haddr  input  AddrWidth  byte address
- htrans  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- hwrite  input  1  1=write
- hsize  input  3  transfer size, log2 bytes
- hwdata  input  32  write data (data phase)
- hready  input  1  bus-level ready (address phase qualifier)
- hreadyout  output  1  this subordinate's ready
- hresp  output  1  0=OKAY, 1=ERROR
- hrdata  output  32  read data
- offset  output  OffsetWidth  register file word index
- wd  output  32  register file write data
- we  output  4  register file byte write enables
- rd  input  32  register file combinational read data

Behaviour:
- Accept: hsel & htrans[1] & hready at a rising edge. IDLE/BUSY or unselected → no data phase, OKAY, no register effect.
- Address phase registers haddr[AddrWidth-1:2] (word index), haddr[1:0], hsize, and hwrite.
- Legality check, evaluated on the address phase; any failure → ERROR:
  - hsize > 2;
  - misaligned: size 1 with haddr[0]=1, size 2 with haddr[1:0]!=0;
  - word index >= NumWords.
- FSM states: IDLE, RD, WR, ERR1, ERR2. Reset state is IDLE.
- Next state on any edge with hready high, evaluated in all states:
  - accepted legal read → RD;
  - accepted legal write → WR;
  - accepted illegal transfer → ERR1;
  - otherwise → IDLE.
- ERR1 → ERR2 unconditionally; ERR1 drives hready low, so no acceptance is possible there.
- Outputs per state:
  - IDLE/RD/WR: hreadyout=1, hresp=0.
  - ERR1: hreadyout=0, hresp=1.
  - ERR2: hreadyout=1, hresp=1.
- offset: registered data-phase word index (truncated to OffsetWidth). Holds its last value when no data phase is active; 0 after reset.
- wd = hwdata in all states, pass-through.
- we: nonzero only in WR, combinational from the registered size/low address:
  - size 0: 4'b0001 << a[1:0];
  - size 1: 4'b0011 << a[1:0];
  - size 2: 4'b1111.
  - The register file commits on the edge ending the WR data phase.
- hrdata = rd in RD, else 32'h0. Read latency is 0 wait states; data is valid in the data phase.
- Read-after-write ordering: write commits before the following read's data phase begins, so back-to-back W then R to the same word returns the new value. No forwarding logic is needed.
- Write during ERROR: we stays 0, no register change.
- Reset values (reset_n low, asynchronous): state IDLE, hreadyout=1, hresp=0, hrdata=0, we=0, offset=0.
- Reset mid-data-phase: an in-flight write is dropped (we=0 immediately).
- Transfer accepted during ERR2 (manager did not cancel): processed normally.

Decomposition:
- Shared package ahb_pkg:
  - htrans_e enum (IDLE/BUSY/NONSEQ/SEQ);
  - hsize constants BYTE/HALF/WORD;
  - HRESP_OKAY/HRESP_ERROR;
  - byte_strobe(size, addr_lo) function returning the 4-bit lane mask.
- FSM state enum stays local to the module.
- No sub-module: strobe decode is a package function. Bench instantiates ahb_reg_bridge + register file.

Test Plan:
- Word write 0x0000_0010 ← 32'hDEADBEEF, then read 0x010 back-to-back → we=4'hF in WR cycle; hrdata=32'hDEADBEEF on the next data phase; hreadyout never low.
- Byte write 8'hA5 to 0x013, halfword write 16'h1234 to 0x010 on a word preset to 0 → we=4'b1000 then 4'b0011; word reads 32'hA500_1234.
- Misaligned halfword write at 0x011 with hwdata=32'hFFFF_FFFF → ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1); we stays 0; word unchanged.
- Out-of-range read at 0x100 (word index 64, NumWords=64) → two-cycle ERROR; hrdata=0.
- hsize=3 write and htrans=BUSY write to 0x020 → ERROR for hsize=3; OKAY with no register change for BUSY.
- Assert reset_n low during the WR data phase of 0x020 ← 32'h55AA55AA → we=0, hreadyout=1, hresp=0 immediately; the register reads 0 after release.
